// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-boundary widths for pipeline stages
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 96;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 37;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer,
// flush with control-zeroing bubbles, and stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W             = 16,
  parameter int DATA_W             = 96,
  parameter int CNT_W              = 16,
  parameter bit ZERO_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t            state, state_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
  logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_ctrl = main_ctrl;
  assign out_data = main_data;

  always_comb begin
    state_n     = state;
    main_ctrl_n = main_ctrl;
    main_data_n = main_data;
    skid_ctrl_n = skid_ctrl;
    skid_data_n = skid_data;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n     = ST_ONE;
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_ctrl_n = in_ctrl;
          main_data_n = in_data;
        end else if (in_fire) begin
          state_n     = ST_FULL;
          skid_ctrl_n = in_ctrl;
          skid_data_n = in_data;
        end else if (out_fire) begin
          // Bubble: control must read zero so downstream enables stay low.
          state_n     = ST_EMPTY;
          main_ctrl_n = '0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_n     = ST_ONE;
          main_ctrl_n = skid_ctrl;
          main_data_n = skid_data;
          skid_ctrl_n = '0;
        end
      end
      default: state_n = ST_EMPTY;
    endcase

    if (flush) begin
      state_n     = ST_EMPTY;
      main_ctrl_n = '0;
      skid_ctrl_n = '0;
      if (ZERO_DATA_ON_FLUSH) begin
        main_data_n = '0;
        skid_data_n = '0;
      end
    end
  end

  // Handshake outputs are flops of the next state, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_n;
      main_ctrl <= main_ctrl_n;
      main_data <= main_data_n;
      skid_ctrl <= skid_ctrl_n;
      skid_data <= skid_data_n;
      in_ready  <= (state_n != ST_FULL);
      out_valid <= (state_n != ST_EMPTY);
      occupancy <= state_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .Reset (Reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .Reset (Reset),
    .inc   (flush & (state != ST_EMPTY)),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

  localparam int CTRL_W  = 16;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [CTRL_W-1:0] q_ctrl[$];
  logic [DATA_W-1:0] q_data[$];
  int                stall_m;
  int                flush_m;
  bit                data_zeroed;

  pipe_stage_skid #(
    .CTRL_W             (CTRL_W),
    .DATA_W             (DATA_W),
    .CNT_W              (CNT_W),
    .ZERO_DATA_ON_FLUSH (1'b1)
  ) dut (
    .clk       (clk),
    .Reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_ctrl.delete();
    q_data.delete();
    stall_m     = 0;
    flush_m     = 0;
    data_zeroed = 1'b1;
  endtask

  // One clock of the stage viewed as a 2-deep FIFO.
  task automatic model_edge();
    int sz;
    bit can_take, has_out;
    sz       = q_ctrl.size();
    can_take = (sz < 2);
    has_out  = (sz > 0);
    if (has_out && !out_ready && stall_m < CNT_MAX) stall_m++;
    if (flush) begin
      if (sz > 0 && flush_m < CNT_MAX) flush_m++;
      q_ctrl.delete();
      q_data.delete();
      data_zeroed = 1'b1;
    end else begin
      if (has_out && out_ready) begin
        void'(q_ctrl.pop_front());
        void'(q_data.pop_front());
      end
      if (in_valid && can_take) begin
        q_ctrl.push_back(in_ctrl);
        q_data.push_back(in_data);
        data_zeroed = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    bit has_out;
    has_out = (q_ctrl.size() > 0);
    check_eq("in_ready", in_ready, q_ctrl.size() < 2);
    check_eq("out_valid", out_valid, has_out);
    check_eq("occupancy", occupancy, q_ctrl.size());
    check_eq("out_ctrl", out_ctrl, has_out ? q_ctrl[0] : '0);
    if (has_out) check_eq("out_data", out_data, q_data[0]);
    else if (data_zeroed) check_eq("out_data_zero", out_data, '0);
    check_eq("stall_cnt", stall_cnt, stall_m);
    check_eq("flush_cnt", flush_cnt, flush_m);
  endtask

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input bit ordy, input bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = $urandom;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_ctrl", out_ctrl, '0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_occupancy", occupancy, 2'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_stall_cnt", stall_cnt, '0);
    check_eq("rst_flush_cnt", flush_cnt, '0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();

    // Backpressure into FULL, then drain in order.
    drive(1'b1, 16'd5, 1'b0, 1'b0); step();
    drive(1'b1, 16'd6, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();

    // Flush while FULL with an offered transfer, then flush while EMPTY.
    drive(1'b1, 16'd5, 1'b0, 1'b0); step();
    drive(1'b1, 16'd6, 1'b0, 1'b0); step();
    drive(1'b1, 16'd9, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b1, 1'b0);    step();
    drive(1'b0, '0, 1'b0, 1'b1);    step();

    // Flush in ONE with a real in_fire: the new entry must be discarded.
    drive(1'b1, 16'd3, 1'b0, 1'b0); step();
    drive(1'b1, 16'd9, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b1, 1'b0);    step();

    // Bubble after ONE drains with no input.
    drive(1'b1, 16'd7, 1'b1, 1'b0); step();
    drive(1'b0, '0, 1'b1, 1'b0);    step();

    // Reset while FULL with skid holding 16'h00FF.
    drive(1'b1, 16'd1, 1'b0, 1'b0);     step();
    drive(1'b1, 16'h00FF, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Stall counter saturation.
    drive(1'b1, 16'd2, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check_eq("stall_sat", stall_cnt, 4'hF);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, CTRL_W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
